// File: rtl/axi4lite_wb_if.sv
// ---------------------------------------------------------------------------
// axi4lite_wb_if
//   Bundles the AXI4-Lite slave channels and the Wishbone classic master
//   signals seen by axi4lite_wb_bridge.
//
//   modport slave  : the bridge's view (AXI4-Lite slave, Wishbone master)
//   modport master : the environment's view (AXI4-Lite master driving the
//                    requests, Wishbone memory returning data and ack)
//
//   AW : AWADDR/AWPROT/AWVALID -> , <- AWREADY
//   W  : WDATA/WSTRB/WVALID    -> , <- WREADY
//   B  : <- BRESP/BVALID       , BREADY ->
//   AR : ARADDR/ARPROT/ARVALID -> , <- ARREADY
//   R  : <- RDATA/RRESP/RVALID , RREADY ->
//   WB : <- wb_cyc_o/wb_stb_o/wb_we_o/wb_addr_o/wb_data_o,
//        wb_data_i/wb_ack_i ->
// ---------------------------------------------------------------------------
interface axi4lite_wb_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] AWADDR;
   logic [2:0]            AWPROT;
   logic                  AWVALID;
   logic                  AWREADY;
   logic [DATA_WIDTH-1:0] WDATA;
   logic [STRB_WIDTH-1:0] WSTRB;
   logic                  WVALID;
   logic                  WREADY;
   logic [1:0]            BRESP;
   logic                  BVALID;
   logic                  BREADY;
   logic [ADDR_WIDTH-1:0] ARADDR;
   logic [2:0]            ARPROT;
   logic                  ARVALID;
   logic                  ARREADY;
   logic [DATA_WIDTH-1:0] RDATA;
   logic [1:0]            RRESP;
   logic                  RVALID;
   logic                  RREADY;

   logic                  wb_cyc_o;
   logic                  wb_stb_o;
   logic                  wb_we_o;
   logic [ADDR_WIDTH-1:0] wb_addr_o;
   logic [DATA_WIDTH-1:0] wb_data_o;
   logic [DATA_WIDTH-1:0] wb_data_i;
   logic                  wb_ack_i;

   modport slave (
      input  AWADDR, AWPROT, AWVALID, output AWREADY,
      input  WDATA, WSTRB, WVALID,    output WREADY,
      output BRESP, BVALID,           input  BREADY,
      input  ARADDR, ARPROT, ARVALID, output ARREADY,
      output RDATA, RRESP, RVALID,    input  RREADY,
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o,
      input  wb_data_i, wb_ack_i
   );

   modport master (
      output AWADDR, AWPROT, AWVALID, input  AWREADY,
      output WDATA, WSTRB, WVALID,    input  WREADY,
      input  BRESP, BVALID,           output BREADY,
      output ARADDR, ARPROT, ARVALID, input  ARREADY,
      input  RDATA, RRESP, RVALID,    output RREADY,
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o,
      output wb_data_i, wb_ack_i
   );
endinterface

// File: rtl/axi4lite_wb_bridge.sv
// ---------------------------------------------------------------------------
// axi4lite_wb_bridge
//   AXI4-Lite slave to Wishbone classic master. One transaction in flight,
//   reads and writes alternate on conflict, partial-strobe writes become a
//   Wishbone read-modify-write because the memory has no byte selects.
//
//   Ports:
//     clk  : system clock, rising edge
//     rst  : synchronous active-high reset
//     bus  : axi4lite_wb_if.slave (AXI4-Lite channels + Wishbone master)
//
//   Parameters:
//     ADDR_WIDTH     : AXI / Wishbone address width
//     DATA_WIDTH     : data width, only 32 is supported
//     TIMEOUT_CYCLES : stb-high cycles without ack before SLVERR (1..255)
// ---------------------------------------------------------------------------
module axi4lite_wb_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic          clk,
   input logic          rst,
   axi4lite_wb_if.slave bus
);
   localparam int              STRB_WIDTH  = DATA_WIDTH / 8;
   localparam logic [1:0]      RESP_OKAY   = 2'b00;
   localparam logic [1:0]      RESP_SLVERR = 2'b10;
   // Last count value before the timeout fires; stb is then high for
   // exactly TIMEOUT_CYCLES cycles.
   localparam logic [7:0]      WAIT_LAST   = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE, RD_BUS, RD_RESP, RMW_RD, WR_BUS, WR_RESP
   } state_t;

   state_t                state, state_nxt;
   logic                  last_was_write;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_WIDTH-1:0] wstrb_q;
   logic [DATA_WIDTH-1:0] wb_data_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [1:0]            bresp_q;
   logic [1:0]            rresp_q;
   logic [7:0]            wait_cnt;
   logic [DATA_WIDTH-1:0] merged;

   logic wr_req, rd_req, take_wr, take_rd, in_bus, timeout;

   // Protection bits and the byte offset of the addresses carry no meaning
   // for a word-addressed memory without byte selects.
   logic unused_bits;
   assign unused_bits = ^{bus.AWPROT, bus.ARPROT, bus.AWADDR[1:0], bus.ARADDR[1:0]};

   // Byte merge of the captured write data over the word read back.
   always_comb begin
      merged = bus.wb_data_i;
      for (int i = 0; i < STRB_WIDTH; i++) begin
         if (wstrb_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
      end
   end

   // Next-state logic and grant decision.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // no path leaves it unassigned and a latch is never inferred.
      state_nxt = state;
      take_wr   = 1'b0;
      take_rd   = 1'b0;
      wr_req    = bus.AWVALID && bus.WVALID;
      rd_req    = bus.ARVALID;
      in_bus    = (state == RD_BUS) || (state == RMW_RD) || (state == WR_BUS);
      timeout   = in_bus && !bus.wb_ack_i && (wait_cnt == WAIT_LAST);

      unique case (state)
         IDLE: begin
            // Gated by rst so no READY is seen while reset is held.
            if (!rst) begin
               if (wr_req && (!rd_req || !last_was_write)) take_wr = 1'b1;
               else if (rd_req)                            take_rd = 1'b1;
            end
            if (take_wr) begin
               if (bus.WSTRB == '1)      state_nxt = WR_BUS;
               else if (bus.WSTRB == '0) state_nxt = WR_RESP;
               else                      state_nxt = RMW_RD;
            end else if (take_rd) begin
               state_nxt = RD_BUS;
            end
         end
         RD_BUS:  if (bus.wb_ack_i || timeout) state_nxt = RD_RESP;
         RMW_RD: begin
            if (bus.wb_ack_i)  state_nxt = WR_BUS;
            else if (timeout)  state_nxt = WR_RESP;
         end
         WR_BUS:  if (bus.wb_ack_i || timeout) state_nxt = WR_RESP;
         RD_RESP: if (bus.RREADY) state_nxt = IDLE;
         WR_RESP: if (bus.BREADY) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state is always assigned with <= so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      // NOTE: the datapath registers are reset too because they drive
      // externally visible outputs that must read 0 after reset.
      if (rst) begin
         last_was_write <= 1'b0;
         addr_q         <= '0;
         wdata_q        <= '0;
         wstrb_q        <= '0;
         wb_data_q      <= '0;
         rdata_q        <= '0;
         bresp_q        <= RESP_OKAY;
         rresp_q        <= RESP_OKAY;
         wait_cnt       <= '0;
      end else begin
         // Counter is zero on entry to any bus state: it only runs while
         // stb waits, and clears on ack, timeout and outside bus states.
         if (in_bus && !bus.wb_ack_i && !timeout) wait_cnt <= wait_cnt + 8'd1;
         else                                      wait_cnt <= '0;

         unique case (state)
            IDLE: begin
               if (take_wr) begin
                  last_was_write <= 1'b1;
                  addr_q         <= {bus.AWADDR[ADDR_WIDTH-1:2], 2'b00};
                  wdata_q        <= bus.WDATA;
                  wstrb_q        <= bus.WSTRB;
                  wb_data_q      <= bus.WDATA;
                  bresp_q        <= RESP_OKAY;
               end else if (take_rd) begin
                  last_was_write <= 1'b0;
                  addr_q         <= {bus.ARADDR[ADDR_WIDTH-1:2], 2'b00};
               end
            end
            RD_BUS: begin
               if (bus.wb_ack_i) begin
                  rdata_q <= bus.wb_data_i;
                  rresp_q <= RESP_OKAY;
               end else if (timeout) begin
                  rdata_q <= '0;
                  rresp_q <= RESP_SLVERR;
               end
            end
            RMW_RD: begin
               if (bus.wb_ack_i)  wb_data_q <= merged;
               else if (timeout)  bresp_q   <= RESP_SLVERR;
            end
            WR_BUS:  if (timeout) bresp_q <= RESP_SLVERR;
            default: ;
         endcase
      end
   end

   assign bus.AWREADY   = take_wr;
   assign bus.WREADY    = take_wr;
   assign bus.ARREADY   = take_rd;
   assign bus.BVALID    = (state == WR_RESP);
   assign bus.BRESP     = bresp_q;
   assign bus.RVALID    = (state == RD_RESP);
   assign bus.RDATA     = rdata_q;
   assign bus.RRESP     = rresp_q;
   assign bus.wb_cyc_o  = in_bus;
   assign bus.wb_stb_o  = in_bus;
   assign bus.wb_we_o   = (state == WR_BUS);
   assign bus.wb_addr_o = addr_q;
   assign bus.wb_data_o = wb_data_q;

endmodule
